mfu_rr_sched: RTL and testbench
===============================

MFU_RR_SCHED -- requirements
Module: mfu_rr_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one mfu instance (legal 2..8).
REQ-002 The block SHALL have the port clk, input, 1 bit, meaning the single clock, rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have the port req_valid, input, NUM_REQ bits, meaning requester i has an operation pending.
REQ-005 The block SHALL have the port req_ready, output, NUM_REQ bits, meaning requester i's operation is accepted this cycle; at most one bit is high.
REQ-006 The block SHALL have the port req_a, input, NUM_REQ bits, meaning operand a per requester.
REQ-007 The block SHALL have the port req_b, input, NUM_REQ bits, meaning operand b per requester.
REQ-008 The block SHALL have the port req_sel, input, 3*NUM_REQ bits, meaning the opcode per requester; requester i uses bits [3i+2:3i].
REQ-009 The block SHALL have the port rsp_valid, output, 1 bit, meaning the response register holds a result.
REQ-010 The block SHALL have the port rsp_ready, input, 1 bit, meaning the consumer accepts the response.
REQ-011 The block SHALL have the port rsp_y, output, 1 bit, meaning the result.
REQ-012 The block SHALL have the port rsp_id, output, $clog2(NUM_REQ) bits, meaning the index of the requester that owns the result.
REQ-013 The block SHALL have the port rsp_err, output, 1 bit, meaning the opcode was reserved (3'b111).

Function
REQ-014 Opcode encoding SHALL be: 000 AND, 001 OR, 010 NOT a (b ignored), 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 reserved (y=0).
REQ-015 Grant SHALL be round-robin: the search starts at (last_grant+1) mod NUM_REQ and the first valid requester wins.
REQ-016 A grant SHALL occur only when at least one req_valid bit is high and the response register can load, i.e. (!rsp_valid || rsp_ready).
REQ-017 req_ready SHALL be combinational from req_valid, the pointer and the load condition, and SHALL never assert for a requester whose req_valid is low.
REQ-018 A transfer SHALL occur when req_valid[i] && req_ready[i]; the operands of requester i SHALL drive the mfu in that cycle.
REQ-019 Latency SHALL be 1: rsp_valid, rsp_y, rsp_id and rsp_err SHALL be registered at the clock edge that completes the transfer.
REQ-020 While rsp_valid && !rsp_ready, all response outputs SHALL hold stable and req_ready SHALL be all zero.
REQ-021 If the response is consumed and a new transfer occurs in the same cycle, rsp_valid SHALL remain 1 with the new data (full throughput, 1 op/cycle).
REQ-022 If the response is consumed and no transfer occurs, rsp_valid SHALL fall to 0 on the next edge.
REQ-023 last_grant SHALL update only on a transfer, never on a stall or an idle cycle.
REQ-024 rsp_err SHALL be 1 exactly when the transferred opcode is 3'b111; in that case rsp_y SHALL be 0 and the response SHALL still be issued.
REQ-025 With a single persistent requester, that requester SHALL be granted every non-stalled cycle.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously clear rsp_valid, rsp_y, rsp_err and rsp_id to 0 and set last_grant to NUM_REQ-1, so that requester 0 has first priority.
REQ-027 During reset req_ready SHALL be all 0; a response pending when reset asserts mid-operation SHALL be discarded.
REQ-028 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Structure
REQ-029 The opcode enum (mfu_op_e: OP_AND..OP_RSVD) and the constant OP_W=3 SHALL live in the shared package mfu_pkg, used by both mfu and this block.
REQ-030 The existing mfu module SHALL be instantiated as the single sub-module, and no opcode decode SHALL be duplicated in this block.
REQ-031 The round-robin priority search SHALL be implemented as a function inside this block, not as a separate module.

Verification
REQ-032 Reset then req_valid=4'b1111 with rsp_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles, and rsp_id follows one cycle later.
REQ-033 Requester 2 with a=1, b=0, sel=101 alone -> req_ready=4'b0100, and the next cycle gives rsp_y=1, rsp_id=2, rsp_err=0.
REQ-034 rsp_ready=0 for 3 cycles with req_valid=4'b0011 -> req_ready=0, and rsp_* held constant for all 3 cycles, then grants resume at last_grant+1.
REQ-035 sel=111 with a=1, b=1 -> rsp_y=0, rsp_err=1, and rsp_valid=1 for one response.
REQ-036 Assert rst_n low while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately (asynchronously), and after release requester 0 wins against 4'b1001.
REQ-037 All 8 opcodes x 4 {a,b} values through requester 1 -> rsp_y matches the REQ-014 table with 0 mismatches.

Source files
------------

// File: rtl/mfu_pkg.sv
// Shared opcode definitions for the mfu and the blocks that feed it.
// OP_W is the opcode width carried per requester.
package mfu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NOTA = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XOR  = 3'b101,
      OP_XNOR = 3'b110,
      OP_RSVD = 3'b111
   } mfu_op_e;

endpackage

// File: rtl/mfu.sv
// Single-bit multi-function logic unit, purely combinational.
// The reserved opcode yields y=0 and raises err.
module mfu
   import mfu_pkg::*;
(
   input  logic            a,
   input  logic            b,
   input  logic [OP_W-1:0] sel,
   output logic            y,
   output logic            err
);

   always_comb begin
      y   = 1'b0;
      err = 1'b0;
      unique case (mfu_op_e'(sel))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOTA: y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_RSVD: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/mfu_rr_sched.sv
// Round-robin scheduler sharing one mfu among NUM_REQ requesters,
// with a single registered response slot (1-cycle latency).
module mfu_rr_sched
   import mfu_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         req_a,
   input  logic [NUM_REQ-1:0]         req_b,
   input  logic [OP_W*NUM_REQ-1:0]    req_sel,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_y,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic                       rsp_err
);

   localparam int IDW = $clog2(NUM_REQ);

   // Returns {found, index}; search starts just after the last grant.
   function automatic logic [IDW:0] rr_pick(
      input logic [NUM_REQ-1:0] v,
      input logic [IDW-1:0]     last
   );
      logic [IDW:0]   pick;
      logic [IDW-1:0] jj;
      int             j;
      pick = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         j  = (int'(last) + i) % NUM_REQ;
         jj = IDW'(j);
         if (v[jj]) pick = {1'b1, jj};
      end
      return pick;
   endfunction

   logic [IDW-1:0]  last_grant;
   logic [IDW:0]    pick;
   logic [IDW-1:0]  gidx;
   logic            load;
   logic            xfer;
   logic            mux_a;
   logic            mux_b;
   logic [OP_W-1:0] mux_sel;
   logic            mfu_y;
   logic            mfu_err;
   logic [OP_W-1:0] sel_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
      assign sel_arr[g] = req_sel[g*OP_W +: OP_W];
   end

   assign load    = !rsp_valid || rsp_ready;
   assign pick    = rr_pick(req_valid, last_grant);
   assign gidx    = pick[IDW-1:0];
   assign xfer    = rst_n && load && pick[IDW];
   assign mux_a   = req_a[gidx];
   assign mux_b   = req_b[gidx];
   assign mux_sel = sel_arr[gidx];

   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[gidx] = 1'b1;
   end

   mfu u_mfu (
      .a   (mux_a),
      .b   (mux_b),
      .sel (mux_sel),
      .y   (mfu_y),
      .err (mfu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_y      <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_id     <= '0;
         last_grant <= IDW'(NUM_REQ - 1);
      end else if (xfer) begin
         rsp_valid  <= 1'b1;
         rsp_y      <= mfu_y;
         rsp_err    <= mfu_err;
         rsp_id     <= gidx;
         last_grant <= gidx;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mfu_rr_sched.sv
// Scoreboard bench for mfu_rr_sched: a reference arbiter and
// logic table predict grants and responses cycle by cycle.
module tb_mfu_rr_sched;

   localparam int N = 4;

   typedef struct {
      logic [1:0] id;
      logic       y;
      logic       err;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_a = '0;
   logic [N-1:0]   req_b = '0;
   logic [3*N-1:0] req_sel = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic           rsp_y;
   logic [1:0]     rsp_id;
   logic           rsp_err;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   m_last = N - 1;
   logic m_valid = 1'b0;

   mfu_rr_sched #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   function automatic logic ref_y(logic [2:0] op, logic a, logic b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return !a;
         3'd3: return !(a & b);
         3'd4: return !(a | b);
         3'd5: return a != b;
         3'd6: return a == b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] ref_grant();
      int i;
      if (!rst_n) return '0;
      if (m_valid && !rsp_ready) return '0;
      i = ref_pick(req_valid, m_last);
      if (i < 0) return '0;
      return N'(1 << i);
   endfunction

   task automatic step_pre(
      input  logic [N-1:0]   v,
      input  logic [N-1:0]   a,
      input  logic [N-1:0]   b,
      input  logic [3*N-1:0] sel,
      input  logic           rr,
      output logic [N-1:0]   g
   );
      exp_t e;
      int   i;
      @(negedge clk);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      req_sel   = sel;
      rsp_ready = rr;
      #1;
      g = ref_grant();
      if (g != '0) begin
         i     = ref_pick(v, m_last);
         e.id  = 2'(i);
         e.y   = ref_y(sel[i*3 +: 3], a[i], b[i]);
         e.err = (sel[i*3 +: 3] == 3'b111);
         sb.push_back(e);
      end
   endtask

   task automatic step_post(input logic [N-1:0] g);
      @(posedge clk);
      #1;
      if (g != '0) begin
         m_valid = 1'b1;
         m_last  = ref_pick(req_valid, m_last);
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (req_ready !== 4'b0000)
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      tests++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== 5'b0)
         $display("FAIL reset_rsp: got %b want 00000",
                  {rsp_valid, rsp_id, rsp_y, rsp_err});
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== 5'b0) fails++;
      if (req_ready !== 4'b0000) fails++;
      req_valid = '0;
      @(negedge clk);
      rst_n   = 1'b1;
      m_last  = N - 1;
      m_valid = 1'b0;
   endtask

   task automatic test_rr_order();
      logic [N-1:0] g;
      logic [N-1:0] want;
      exp_t         e;
      for (int k = 0; k < 5; k++) begin
         step_pre('1, 4'($urandom), 4'($urandom), 12'($urandom), 1'b1, g);
         want = 4'(1 << (k % 4));
         tests++;
         if (req_ready !== want) begin
            fails++;
            $display("FAIL rr_seq: got %b want %b", req_ready, want);
         end
         step_post(g);
         e = sb.pop_front();
         tests++;
         if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, e.id, e.y, e.err}) begin
            fails++;
            $display("FAIL rr_rsp: got %b want %b",
                     {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, e.id, e.y, e.err});
         end
      end
   endtask

   task automatic test_single();
      logic [N-1:0] g;
      exp_t         e;
      step_pre(4'b0100, 4'b0100, 4'b0000, 12'b000_101_000_000, 1'b1, g);
      tests++;
      if (req_ready !== 4'b0100) begin
         fails++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      step_post(g);
      e = sb.pop_front();
      tests++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, e.id, e.y, e.err}
          || {rsp_valid, rsp_id, rsp_y, rsp_err} !== 5'b1_10_1_0) begin
         fails++;
         $display("FAIL single_rsp: got %b want 11010",
                  {rsp_valid, rsp_id, rsp_y, rsp_err});
      end
   endtask

   task automatic test_stall();
      logic [N-1:0] g;
      logic [4:0]   snap;
      exp_t         e;
      step_pre(4'b0011, 4'($urandom), 4'($urandom), 12'($urandom), 1'b1, g);
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL stall_pre: got %b want 0001", req_ready);
      end
      step_post(g);
      e = sb.pop_front();
      snap = {rsp_valid, rsp_id, rsp_y, rsp_err};
      tests++;
      if (snap !== {1'b1, e.id, e.y, e.err}) begin
         fails++;
         $display("FAIL stall_first: got %b want %b", snap, {1'b1, e.id, e.y, e.err});
      end
      for (int k = 0; k < 3; k++) begin
         step_pre(4'b0011, 4'($urandom), 4'($urandom), 12'($urandom), 1'b0, g);
         tests++;
         if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL stall_ready: got %b want 0000", req_ready);
         end
         step_post(g);
         tests++;
         if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== snap) begin
            fails++;
            $display("FAIL stall_hold: got %b want %b",
                     {rsp_valid, rsp_id, rsp_y, rsp_err}, snap);
         end
      end
      step_pre(4'b0011, 4'($urandom), 4'($urandom), 12'($urandom), 1'b1, g);
      tests++;
      if (req_ready !== 4'b0010 || req_ready !== g) begin
         fails++;
         $display("FAIL stall_resume: got %b want 0010", req_ready);
      end
      step_post(g);
      e = sb.pop_front();
      tests++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, e.id, e.y, e.err}) begin
         fails++;
         $display("FAIL resume_rsp: got %b want %b",
                  {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, e.id, e.y, e.err});
      end
      step_pre(4'b0000, '0, '0, '0, 1'b1, g);
      step_post(g);
      tests++;
      if (rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL drain: rsp_valid=%b want 0", rsp_valid);
      end
   endtask

   task automatic test_rsvd();
      logic [N-1:0] g;
      exp_t         e;
      step_pre(4'b0010, 4'b0010, 4'b0010, 12'b000_000_111_000, 1'b1, g);
      step_post(g);
      e = sb.pop_front();
      tests++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== 5'b1_01_0_1
          || e.err !== 1'b1) begin
         fails++;
         $display("FAIL rsvd: got %b want 10101",
                  {rsp_valid, rsp_id, rsp_y, rsp_err});
      end
      step_pre(4'b0000, '0, '0, '0, 1'b1, g);
      step_post(g);
      tests++;
      if (rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL rsvd_once: rsp_valid=%b want 0", rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] g;
      exp_t         e;
      step_pre(4'b0001, 4'($urandom), 4'($urandom), 12'($urandom), 1'b1, g);
      step_post(g);
      e = sb.pop_front();
      step_pre(4'b1001, 4'($urandom), 4'($urandom), 12'($urandom), 1'b0, g);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         fails++;
         $display("FAIL async_rst: rsp_valid=%b req_ready=%b want 0/0000",
                  rsp_valid, req_ready);
      end
      sb.delete();
      m_last    = N - 1;
      m_valid   = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step_pre(4'b1001, 4'($urandom), 4'($urandom), 12'($urandom), 1'b1, g);
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL post_rst_grant: got %b want 0001", req_ready);
      end
      step_post(g);
      e = sb.pop_front();
      tests++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, e.id, e.y, e.err}) begin
         fails++;
         $display("FAIL post_rst_rsp: got %b want %b",
                  {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, e.id, e.y, e.err});
      end
   endtask

   task automatic test_ops();
      logic [N-1:0] g;
      exp_t         e;
      for (int op = 0; op < 8; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            step_pre(4'b0010, 4'(((ab >> 1) & 1) << 1), 4'((ab & 1) << 1),
                     12'(op << 3), 1'b1, g);
            step_post(g);
            e = sb.pop_front();
            tests++;
            if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, e.id, e.y, e.err}) begin
               fails++;
               $display("FAIL op%0d_ab%0d: got %b want %b", op, ab,
                        {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, e.id, e.y, e.err});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] g;
      exp_t         e;
      for (int k = 0; k < 80; k++) begin
         step_pre(4'($urandom), 4'($urandom), 4'($urandom), 12'($urandom),
                  ($urandom_range(0, 3) != 0), g);
         tests++;
         if (req_ready !== g) begin
            fails++;
            $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, g);
         end
         step_post(g);
         if (g != '0) begin
            e = sb.pop_front();
            tests++;
            if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, e.id, e.y, e.err}) begin
               fails++;
               $display("FAIL b2b_rsp%0d: got %b want %b", k,
                        {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, e.id, e.y, e.err});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rr_order();
      test_single();
      test_stall();
      test_rsvd();
      test_reset_mid();
      test_ops();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
